// File: rtl/dmem_responder.sv
// Word-access byte-array data memory responder, big-endian, valid/ready request and response channels.
// Latency: request accepted at edge N, response valid from edge N+1+LATENCY. Backpressure: response held until rsp_ready; req_ready only in IDLE.
// Optional: define DMEM_ALIGN_CHECK_EN to reject misaligned accesses with rsp_err.
module dmem_responder #(
    parameter int ADDR_W  = 5,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rdy_q, rdy_d;
    logic              vld_q, vld_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] byte_addr [4];
    logic [31:0]       rd_word;
    logic              misal;
    logic              mem_we;

    // Byte lanes wrap modulo the storage size.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            byte_addr[k] = addr_q + ADDR_W'(k);
        end
    end

    assign rd_word = {mem_q[byte_addr[0]], mem_q[byte_addr[1]],
                      mem_q[byte_addr[2]], mem_q[byte_addr[3]]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign misal = (addr_q[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdy_d   = rdy_q;
        vld_d   = vld_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                rdy_d = 1'b1;
                if (req_valid && rdy_q) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdy_d   = 1'b0;
                    // Counter holds the number of wait edges left before the access edge.
                    cnt_d   = CNT_W'(LATENCY);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    vld_d   = 1'b1;
                    err_d   = misal;
                    mem_we  = wr_q && !misal;
                    rdata_d = (wr_q || misal) ? 32'h0 : rd_word;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    vld_d   = 1'b0;
                    rdy_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset; reset forces IDLE so mem_we is low while rst_n is asserted.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[byte_addr[k]] <= wdata_q[31-8*k -: 8];
            end
        end
    end

    assign req_ready = rdy_q;
    assign rsp_valid = vld_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 0, 3) driven from a vector table and corner sequences.
// Expected responses are queued at request acceptance and compared when the response handshake occurs.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_write [3];
    logic [4:0]  req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        dmem_responder #(
            .ADDR_W (5),
            .LATENCY(gi == 0 ? 2 : (gi == 1 ? 0 : 3))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .req_valid(req_valid[gi]),
            .req_ready(req_ready[gi]),
            .req_write(req_write[gi]),
            .req_addr (req_addr[gi]),
            .req_wdata(req_wdata[gi]),
            .rsp_valid(rsp_valid[gi]),
            .rsp_ready(rsp_ready[gi]),
            .rsp_rdata(rsp_rdata[gi]),
            .rsp_err  (rsp_err[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        logic        w;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    rsp_t sb_q[$];
    vec_t vecs[$];
    int   n_run;
    int   n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic w, input logic [4:0] a, input logic [31:0] wd,
                           input logic [31:0] er, input logic ee);
        vec_t v;
        v = '{w, a, wd, er, ee};
        vecs.push_back(v);
    endtask

    // Full transaction on instance d; called with time at 1 unit after a rising edge.
    task automatic run_txn(input int d, input logic w, input logic [4:0] a, input logic [31:0] wd,
                           input logic [31:0] er, input logic ee, input string nm, output int lat);
        int   k;
        rsp_t e;
        rsp_t x;
        k = 0;
        while (!req_ready[d] && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk({nm, "_req_ready"}, 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_write[d] = w;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        @(posedge clk); #1;
        x = '{er, ee};
        sb_q.push_back(x);
        req_valid[d] = 1'b0;
        req_write[d] = 1'b0;
        chk({nm, "_ready_drop"}, 32'(req_ready[d]), 32'd0);
        k = 0;
        while (!rsp_valid[d] && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        lat = k;
        if (!rsp_valid[d]) begin
            n_run++;
            n_fail++;
            $display("FAIL %s_timeout: rsp_valid never rose", nm);
            void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            chk({nm, "_rdata"}, rsp_rdata[d], e.rdata);
            chk({nm, "_err"}, 32'(rsp_err[d]), 32'(e.err));
            rsp_ready[d] = 1'b1;
            @(posedge clk); #1;
            rsp_ready[d] = 1'b0;
            chk({nm, "_vld_clear"}, 32'(rsp_valid[d]), 32'd0);
            chk({nm, "_ready_back"}, 32'(req_ready[d]), 32'd1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;
        n_run  = 0;
        n_fail = 0;
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            rsp_ready[d] = 1'b0;
        end

`ifdef DMEM_ALIGN_CHECK_EN
        add_vec(1'b1, 5'h04, 32'hA0A1A2A3, 32'h0,        1'b0);
        add_vec(1'b1, 5'h08, 32'hB0B1B2B3, 32'h0,        1'b0);
        add_vec(1'b1, 5'h06, 32'h55667788, 32'h0,        1'b1);
        add_vec(1'b0, 5'h04, 32'h0,        32'hA0A1A2A3, 1'b0);
        add_vec(1'b0, 5'h08, 32'h0,        32'hB0B1B2B3, 1'b0);
        add_vec(1'b0, 5'h05, 32'h0,        32'h0,        1'b1);
        add_vec(1'b0, 5'h1F, 32'h0,        32'h0,        1'b1);
        add_vec(1'b1, 5'h08, 32'h11223344, 32'h0,        1'b0);
        add_vec(1'b0, 5'h08, 32'h0,        32'h11223344, 1'b0);
        add_vec(1'b1, 5'h1C, 32'hAABBCCDD, 32'h0,        1'b0);
        add_vec(1'b0, 5'h1C, 32'h0,        32'hAABBCCDD, 1'b0);
`else
        add_vec(1'b1, 5'h04, 32'h00000000, 32'h0,        1'b0);
        add_vec(1'b1, 5'h0C, 32'h00000000, 32'h0,        1'b0);
        add_vec(1'b1, 5'h08, 32'h11223344, 32'h0,        1'b0);
        add_vec(1'b0, 5'h08, 32'h0,        32'h11223344, 1'b0);
        add_vec(1'b0, 5'h05, 32'h0,        32'h00000011, 1'b0);
        add_vec(1'b0, 5'h0B, 32'h0,        32'h44000000, 1'b0);
        add_vec(1'b1, 5'h1C, 32'h01020304, 32'h0,        1'b0);
        add_vec(1'b1, 5'h00, 32'h00000000, 32'h0,        1'b0);
        add_vec(1'b1, 5'h1E, 32'hAABBCCDD, 32'h0,        1'b0);
        add_vec(1'b0, 5'h1C, 32'h0,        32'h0102AABB, 1'b0);
        add_vec(1'b0, 5'h00, 32'h0,        32'hCCDD0000, 1'b0);
        add_vec(1'b0, 5'h1E, 32'h0,        32'hAABBCCDD, 1'b0);
        add_vec(1'b1, 5'h10, 32'hDEADBEEF, 32'h0,        1'b0);
        add_vec(1'b0, 5'h10, 32'h0,        32'hDEADBEEF, 1'b0);
`endif

        // Reset state and registered req_ready rise.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_req_ready%0d", d), 32'(req_ready[d]), 32'd0);
            chk($sformatf("rst_rsp_valid%0d", d), 32'(rsp_valid[d]), 32'd0);
            chk($sformatf("rst_rsp_rdata%0d", d), rsp_rdata[d], 32'd0);
            chk($sformatf("rst_rsp_err%0d", d), 32'(rsp_err[d]), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("rel_ready_before_edge", 32'(req_ready[0]), 32'd0);
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rel_ready_after_edge%0d", d), 32'(req_ready[d]), 32'd1);
        end

        // Vector table on the LATENCY=2 instance.
        for (int i = 0; i < vecs.size(); i++) begin
            run_txn(0, vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                    vecs[i].exp_err, $sformatf("vec%0d", i), lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
        end

        // LATENCY=0 instance: response one edge after acceptance.
        run_txn(1, 1'b1, 5'h08, 32'h11223344, 32'h0, 1'b0, "l0_wr", lat);
        chk("l0_wr_latency", 32'(lat), 32'd1);
        run_txn(1, 1'b0, 5'h08, 32'h0, 32'h11223344, 1'b0, "l0_rd", lat);
        chk("l0_rd_latency", 32'(lat), 32'd1);

        // Backpressure: response held 4 cycles while a stray request is presented.
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 5'h08;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        k = 0;
        while (!rsp_valid[0] && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        for (int i = 0; i < 4; i++) begin
            req_valid[0] = 1'b1;
            req_write[0] = 1'b1;
            req_wdata[0] = 32'hFFFFFFFF;
            chk($sformatf("bp_vld%0d", i), 32'(rsp_valid[0]), 32'd1);
            chk($sformatf("bp_rdata%0d", i), rsp_rdata[0], 32'h11223344);
            chk($sformatf("bp_ready%0d", i), 32'(req_ready[0]), 32'd0);
            @(posedge clk); #1;
        end
        req_valid[0] = 1'b0;
        req_write[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        chk("bp_ready_after", 32'(req_ready[0]), 32'd1);
        chk("bp_vld_after", 32'(rsp_valid[0]), 32'd0);
        run_txn(0, 1'b0, 5'h08, 32'h0, 32'h11223344, 1'b0, "bp_reread", lat);

        // Reset in WAIT on the LATENCY=3 instance abandons the pending write.
        run_txn(2, 1'b1, 5'h04, 32'h0BADF00D, 32'h0, 1'b0, "l3_wr", lat);
        chk("l3_wr_latency", 32'(lat), 32'd4);
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 5'h04;
        req_wdata[2] = 32'h12345678;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        req_write[2] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstw_vld", 32'(rsp_valid[2]), 32'd0);
        chk("rstw_ready", 32'(req_ready[2]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rstw_ready_pre", 32'(req_ready[2]), 32'd0);
        @(posedge clk); #1;
        chk("rstw_ready_post", 32'(req_ready[2]), 32'd1);
        run_txn(2, 1'b0, 5'h04, 32'h0, 32'h0BADF00D, 1'b0, "rstw_reread", lat);

        // Reset in RESP drops rsp_valid without waiting for an edge.
        req_valid[2] = 1'b1;
        req_addr[2]  = 5'h04;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        k = 0;
        while (!rsp_valid[2] && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rstr_vld_before", 32'(rsp_valid[2]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstr_vld_async", 32'(rsp_valid[2]), 32'd0);
        chk("rstr_rdata_async", rsp_rdata[2], 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstr_ready_post", 32'(req_ready[2]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
